crc_check: RTL and testbench
============================

# crc_check

Bit-serial CRC checker: the receive-side counterpart to the team's bit-serial `crc` generator. It accepts a framed serial bit stream and, when the frame ends, reports whether the trailing BITS bits match the CRC computed over the preceding message bits.

- The transmitter sends the message bits, then the generator's `crc_out` MSB-first.
- The checker uses the Direct Method with the same POLY, INIT, XOR_OUT and REF_OUT semantics.
- It sits behind the serial deframer, in front of the packet-accept logic.

## Interface
Parameters:
- BITS, 8, CRC width (≥ 2)
- POLY, 8'h9B, CRC polynomial (implicit top bit omitted)
- INIT, 8'h00, CRC register value at start of frame
- XOR_OUT, 8'h00, constant XORed onto the (possibly reflected) CRC
- REF_OUT, 1, 1 = bit-reverse the CRC register before XOR_OUT

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- data  in  1  serial bit
- enable  in  1  `data`/`sof`/`eof` are valid on this rising edge
- sof  in  1  marks the first bit of a frame; qualified by `enable`
- eof  in  1  marks the last bit of a frame (last CRC bit); qualified by `enable`
- done  out  1  one-cycle pulse: frame result valid
- crc_ok  out  1  received CRC equals computed CRC; held until the next `done`
- short_err  out  1  frame had fewer than BITS+1 bits; held until the next `done`
- crc_val  out  BITS  computed CRC of the message (after reflect/XOR_OUT); held until the next `done`

## Operation
- State machine IDLE / RECV; the reset state is IDLE.
- A beat is a rising edge with `enable`=1. Without `enable`, all state holds. `sof`/`eof` are ignored unless `enable`=1.
- **IDLE:**
  - A beat with `sof`=1 starts a frame: bit count cnt←1, delay line dly←{…, data}, crc_reg←INIT, go to RECV.
  - A beat without `sof` is ignored (`eof` included).
- **RECV, per beat:**
  - dly shifts left with `data` entering at the LSB.
  - When cnt ≥ BITS, the bit leaving dly (dly[BITS-1]) is fed to the CRC engine: crc_reg←{crc_reg[BITS-2:0],0} ^ (crc_reg[BITS-1]^bit ? POLY : 0).
  - cnt increments and saturates at BITS+1.
- **sof during RECV:** the current frame is abandoned with no `done`, and the beat is treated as the first bit of a new frame exactly as in IDLE.
- **eof beat (RECV, or the sof beat itself):** go to IDLE and register the results:
  - N = total frame bits including this one; received CRC = {dly[BITS-2:0], data}.
  - Expected = transform(crc_reg after this beat's update), where transform = (REF_OUT ? bit-reverse : identity), then ^XOR_OUT.
  - If N ≥ BITS+1: crc_ok←(received==expected), short_err←0, crc_val←expected.
  - If N < BITS+1: crc_ok←0, short_err←1, crc_val←transform(INIT).
  - `sof`=`eof`=1 on the same beat is a 1-bit frame, so short_err=1.
- A zero-length message is illegal; it is reported as short.
- The engine processes exactly N−BITS message bits; the final BITS bits never enter it.

## Timing
- Reset (asynchronous, immediate): state IDLE, cnt 0, dly 0, crc_reg INIT, done 0, crc_ok 0, short_err 0, crc_val 0.
- `done` goes high after the edge that accepts the eof beat and lasts exactly one cycle, whether or not `enable` is high on the next edge.
- crc_ok, short_err and crc_val update on that same edge and hold until the next `done`.
- A new frame's sof may arrive on the edge immediately after eof, giving back-to-back frames with no gap cycle.
- Reset asserted mid-frame discards the frame; no `done` is produced.
- The data path is fully serial: 1 bit per enabled clock, with no backpressure.

## Test plan
- Defaults (CRC-8/WCDMA): ASCII "123456789" sent byte-wise LSB-first (72 bits), then 0x25 MSB-first (0,0,1,0,0,1,0,1), eof on the last bit. Required: done pulses once; crc_ok=1, short_err=0, crc_val=8'h25.
- Same frame with bit 10 inverted. Required: done; crc_ok=0, crc_val≠8'h25.
- sof with data=0, then eight 0 bits, eof on the 9th bit. Required: crc_ok=1, crc_val=8'h00. Repeat with `enable` toggled low every other cycle; the result must be identical.
- 8-bit frame (sof … eof, 8 beats). Required: done; short_err=1, crc_ok=0. A sof+eof single-beat frame gives the same result.
- Start the "123456789" frame, then issue sof again after 30 bits followed by the full valid frame. Required: exactly one done, with crc_ok=1. Asserting rst mid-frame produces no done, and all outputs read 0 immediately, without waiting for a clock edge.
- Two valid frames back-to-back (sof on the cycle after eof). Required: two done pulses, both with crc_ok=1.

Source files
------------

// File: rtl/crc_check.sv
// Bit-serial CRC checker: recomputes the CRC over a framed serial stream and
// compares it against the trailing BITS bits sent MSB-first by the generator.
module crc_check #(
    parameter int unsigned     BITS    = 8,
    parameter logic [BITS-1:0] POLY    = 8'h9B,
    parameter logic [BITS-1:0] INIT    = 8'h00,
    parameter logic [BITS-1:0] XOR_OUT = 8'h00,
    parameter bit              REF_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            data,
    input  logic            enable,
    input  logic            sof,
    input  logic            eof,
    output logic            done,
    output logic            crc_ok,
    output logic            short_err,
    output logic [BITS-1:0] crc_val
);

    localparam int unsigned    CW       = $clog2(BITS + 2);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(BITS + 1);
    localparam logic [CW-1:0]  CNT_FEED = CW'(BITS);

    typedef enum logic {StIdle, StRecv} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] dly;
    logic [BITS-1:0] crc_reg;

    logic            active;
    logic [CW-1:0]   cnt_d;
    logic [BITS-1:0] dly_d;
    logic [BITS-1:0] crc_d;
    logic [BITS-1:0] exp_crc;

    function automatic logic [BITS-1:0] transform(input logic [BITS-1:0] r);
        logic [BITS-1:0] t;
        for (int i = 0; i < int'(BITS); i++) begin
            t[i] = REF_OUT ? r[BITS-1-i] : r[i];
        end
        return t ^ XOR_OUT;
    endfunction

    function automatic logic [BITS-1:0] crc_step(input logic [BITS-1:0] r, input logic b);
        return {r[BITS-2:0], 1'b0} ^ ((r[BITS-1] ^ b) ? POLY : '0);
    endfunction

    always_comb begin
        // A sof beat restarts the frame whether idle or mid-frame.
        active = enable && (sof || state == StRecv);
        dly_d  = {dly[BITS-2:0], data};
        if (sof) begin
            cnt_d = CW'(1);
            crc_d = INIT;
        end else begin
            cnt_d = (cnt < CNT_MAX) ? cnt + CW'(1) : cnt;
            // Bits leave the delay line only once it holds a full CRC's worth.
            crc_d = (cnt >= CNT_FEED) ? crc_step(crc_reg, dly[BITS-1]) : crc_reg;
        end
        exp_crc = transform(crc_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            dly       <= '0;
            crc_reg   <= INIT;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            short_err <= 1'b0;
            crc_val   <= '0;
        end else begin
            done <= 1'b0;
            if (active) begin
                cnt     <= cnt_d;
                dly     <= dly_d;
                crc_reg <= crc_d;
                if (eof) begin
                    state <= StIdle;
                    done  <= 1'b1;
                    if (cnt_d == CNT_MAX) begin
                        crc_ok    <= (dly_d == exp_crc);
                        short_err <= 1'b0;
                        crc_val   <= exp_crc;
                    end else begin
                        crc_ok    <= 1'b0;
                        short_err <= 1'b1;
                        crc_val   <= transform(INIT);
                    end
                end else begin
                    state <= StRecv;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: directed CRC-8/WCDMA vectors plus random
// frames checked against a frame-level reference model.
module tb_crc_check;

    localparam int         BITS    = 8;
    localparam logic [7:0] POLY    = 8'h9B;
    localparam logic [7:0] INIT    = 8'h00;
    localparam logic [7:0] XOR_OUT = 8'h00;
    localparam bit         REF_OUT = 1'b1;

    typedef bit bitq_t[$];
    typedef struct {
        logic            ok;
        logic            sh;
        logic [BITS-1:0] val;
    } res_t;

    logic            clk, rst, data, enable, sof, eof;
    logic            done, crc_ok, short_err;
    logic [BITS-1:0] crc_val;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t resq[$];

    crc_check #(
        .BITS(BITS), .POLY(POLY), .INIT(INIT), .XOR_OUT(XOR_OUT), .REF_OUT(REF_OUT)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .enable(enable), .sof(sof), .eof(eof),
        .done(done), .crc_ok(crc_ok), .short_err(short_err), .crc_val(crc_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle with done high records one result, so a stuck done shows up as extras.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            res_t r;
            r.ok  = crc_ok;
            r.sh  = short_err;
            r.val = crc_val;
            resq.push_back(r);
        end
    end

    // Reference model: frame-level view of the checker.
    function automatic logic [BITS-1:0] xform(input logic [BITS-1:0] r);
        logic [BITS-1:0] t;
        t = r;
        if (REF_OUT) for (int i = 0; i < BITS; i++) t[i] = r[BITS-1-i];
        return t ^ XOR_OUT;
    endfunction

    function automatic logic [BITS-1:0] msg_crc(input bitq_t f, input int nmsg);
        logic [BITS-1:0] r;
        logic            fb;
        r = INIT;
        for (int i = 0; i < nmsg; i++) begin
            fb = r[BITS-1] ^ f[i];
            r  = r << 1;
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    task automatic predict(input bitq_t f, output logic ok, output logic sh,
                           output logic [BITS-1:0] val);
        logic [BITS-1:0] rcv;
        int              n;
        n = f.size();
        if (n < BITS + 1) begin
            ok = 1'b0; sh = 1'b1; val = xform(INIT);
        end else begin
            rcv = '0;
            for (int i = n - BITS; i < n; i++) rcv = {rcv[BITS-2:0], 1'(f[i])};
            val = xform(msg_crc(f, n - BITS));
            ok  = (rcv == val);
            sh  = 1'b0;
        end
    endtask

    function automatic bitq_t vec_frame();
        bitq_t      q;
        string      s;
        logic [7:0] c;
        logic [7:0] k;
        s = "123456789";
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            for (int b = 0; b < 8; b++) q.push_back(c[b]);
        end
        k = 8'h25;
        for (int b = 7; b >= 0; b--) q.push_back(k[b]);
        return q;
    endfunction

    task automatic beat(input logic d, input logic en, input logic s, input logic e);
        data = d; enable = en; sof = s; eof = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // gap: 0 none, 1 one disabled garbage cycle between beats, 2 random gaps.
    task automatic send_frame(input bitq_t f, input int gap, input bit close);
        for (int i = 0; i < f.size(); i++) begin
            if (gap == 1 && i > 0)
                beat(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
            else if (gap == 2)
                repeat ($urandom_range(0, 2)) beat(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
            beat(1'(f[i]), 1'b1, i == 0, close && (i == f.size() - 1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data = 1'b0; enable = 1'b0; sof = 1'b0; eof = 1'b0;
        #3;
        n_checks++;
        if ({done, crc_ok, short_err, crc_val} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, expected all zero",
                     {done, crc_ok, short_err, crc_val});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(1);
        n_checks++;
        if (resq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses, expected 0", resq.size());
        end
        resq.delete();
    endtask

    task automatic test_vector();
        res_t r;
        send_frame(vec_frame(), 0, 1);
        idle(3);
        n_checks++;
        if (resq.size() != 1) begin
            n_fail++;
            $display("FAIL vector_done: got %0d pulses, expected 1", resq.size());
        end else begin
            r = resq.pop_front();
            n_checks++;
            if (r.ok !== 1'b1 || r.sh !== 1'b0 || r.val !== 8'h25) begin
                n_fail++;
                $display("FAIL vector_result: got ok=%b sh=%b val=%h, expected ok=1 sh=0 val=25",
                         r.ok, r.sh, r.val);
            end
        end
        resq.delete();
    endtask

    task automatic test_corrupt();
        bitq_t f;
        res_t  r;
        f = vec_frame();
        f[10] = ~f[10];
        send_frame(f, 0, 1);
        idle(2);
        n_checks++;
        if (resq.size() != 1) begin
            n_fail++;
            $display("FAIL corrupt_done: got %0d pulses, expected 1", resq.size());
        end else begin
            r = resq.pop_front();
            n_checks++;
            if (r.ok !== 1'b0 || r.sh !== 1'b0 || r.val === 8'h25) begin
                n_fail++;
                $display("FAIL corrupt_result: got ok=%b sh=%b val=%h, expected ok=0 sh=0 val!=25",
                         r.ok, r.sh, r.val);
            end
        end
        resq.delete();
    endtask

    task automatic test_zero_gapped();
        bitq_t f;
        res_t  r;
        for (int i = 0; i < 9; i++) f.push_back(1'b0);
        for (int g = 0; g < 2; g++) begin
            send_frame(f, g, 1);
            idle(2);
            n_checks++;
            if (resq.size() != 1) begin
                n_fail++;
                $display("FAIL zero_done gap=%0d: got %0d pulses, expected 1", g, resq.size());
            end else begin
                r = resq.pop_front();
                n_checks++;
                if (r.ok !== 1'b1 || r.sh !== 1'b0 || r.val !== 8'h00) begin
                    n_fail++;
                    $display("FAIL zero_result gap=%0d: got ok=%b sh=%b val=%h, expected 1/0/00",
                             g, r.ok, r.sh, r.val);
                end
            end
            resq.delete();
        end
    endtask

    task automatic test_short();
        bitq_t f;
        res_t  r;
        for (int len = 8; len >= 1; len -= 7) begin
            f.delete();
            for (int i = 0; i < len; i++) f.push_back(1'($urandom));
            send_frame(f, 0, 1);
            idle(2);
            n_checks++;
            if (resq.size() != 1) begin
                n_fail++;
                $display("FAIL short_done len=%0d: got %0d pulses, expected 1", len, resq.size());
            end else begin
                r = resq.pop_front();
                n_checks++;
                if (r.ok !== 1'b0 || r.sh !== 1'b1 || r.val !== xform(INIT)) begin
                    n_fail++;
                    $display("FAIL short_result len=%0d: got ok=%b sh=%b val=%h, expected 0/1/%h",
                             len, r.ok, r.sh, r.val, xform(INIT));
                end
            end
            resq.delete();
        end
    endtask

    task automatic test_abort_sof();
        bitq_t f;
        res_t  r;
        f = vec_frame();
        send_frame(f[0:29], 0, 0);
        send_frame(f, 0, 1);
        idle(2);
        n_checks++;
        if (resq.size() != 1) begin
            n_fail++;
            $display("FAIL abort_done: got %0d pulses, expected 1", resq.size());
        end else begin
            r = resq.pop_front();
            n_checks++;
            if (r.ok !== 1'b1 || r.val !== 8'h25) begin
                n_fail++;
                $display("FAIL abort_result: got ok=%b val=%h, expected ok=1 val=25", r.ok, r.val);
            end
        end
        resq.delete();
    endtask

    task automatic test_reset_mid();
        bitq_t f;
        f = vec_frame();
        send_frame(f, 0, 1);
        idle(2);
        resq.delete();
        send_frame(f[0:29], 0, 0);
        // Assert reset between edges: outputs must clear without a clock.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({done, crc_ok, short_err, crc_val} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got ok=%b sh=%b val=%h, expected all zero",
                     crc_ok, short_err, crc_val);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        // Remaining bits without sof must be ignored; the old frame is gone.
        for (int i = 30; i < f.size(); i++) beat(1'(f[i]), 1'b1, 1'b0, i == f.size() - 1);
        idle(2);
        n_checks++;
        if (resq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_done: got %0d pulses, expected 0", resq.size());
        end
        resq.delete();
    endtask

    task automatic test_back_to_back();
        bitq_t f;
        res_t  r;
        f = vec_frame();
        send_frame(f, 0, 1);
        send_frame(f, 0, 1);
        idle(2);
        n_checks++;
        if (resq.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses, expected 2", resq.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                r = resq.pop_front();
                n_checks++;
                if (r.ok !== 1'b1 || r.sh !== 1'b0 || r.val !== 8'h25) begin
                    n_fail++;
                    $display("FAIL b2b_result #%0d: got ok=%b sh=%b val=%h, expected 1/0/25",
                             k, r.ok, r.sh, r.val);
                end
            end
        end
        resq.delete();
    endtask

    task automatic test_random();
        bitq_t           f;
        res_t            r;
        logic            eok, esh;
        logic [BITS-1:0] eval, c;
        int              nmsg;
        for (int t = 0; t < 40; t++) begin
            f.delete();
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, BITS)) f.push_back(1'($urandom));
            end else begin
                nmsg = $urandom_range(1, 40);
                repeat (nmsg) f.push_back(1'($urandom));
                c = xform(msg_crc(f, nmsg));
                for (int b = BITS - 1; b >= 0; b--) f.push_back(c[b]);
                if ($urandom_range(0, 2) == 0) begin
                    int p = $urandom_range(0, f.size() - 1);
                    f[p] = ~f[p];
                end
            end
            predict(f, eok, esh, eval);
            send_frame(f, $urandom_range(0, 2), 1);
            if ($urandom_range(0, 1) == 1) idle(2);
            else idle(1);
            n_checks++;
            if (resq.size() != 1) begin
                n_fail++;
                $display("FAIL rand_done #%0d: got %0d pulses, expected 1", t, resq.size());
            end else begin
                r = resq.pop_front();
                n_checks++;
                if (r.ok !== eok || r.sh !== esh || r.val !== eval) begin
                    n_fail++;
                    $display("FAIL rand_result #%0d len=%0d: got ok=%b sh=%b val=%h, expected ok=%b sh=%b val=%h",
                             t, f.size(), r.ok, r.sh, r.val, eok, esh, eval);
                end
            end
            resq.delete();
        end
    endtask

    initial begin
        test_reset();
        test_vector();
        test_corrupt();
        test_zero_gapped();
        test_short();
        test_abort_sof();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
